ahb_bus_arbiter: RTL
====================

# ahb_bus_arbiter

Single-master AHB-Lite front end that shares one bus between the CPU instruction-fetch port and data load/store port. Arbitrates between the two requesters, sequences the address and data phases, and drives the ROM/RAM response-mux select (muxsel) for the data phase. Returns read data, completion and error status to the winning requester. Sits between the core's fetch/LSU and the ROM/RAM slaves plus the response mux.

## Interface
- ROM_LIMIT, 32'h0000_8000: byte addresses below this decode to ROM (muxsel=1); all others decode to RAM (muxsel=0).
- DATA_STREAK, 4: maximum consecutive data grants while an instruction request waits.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- if_req  in  1  instruction read request, level, held until if_ack.
- if_addr  in  32  instruction address, word aligned, stable while if_req.
- if_ack  out  1  one-cycle completion pulse to fetch.
- if_err  out  1  error flag, valid with if_ack.
- if_rdata  out  32  read data, valid with if_ack.
- d_req  in  1  data request, level, held until d_ack.
- d_we  in  1  1 = write.
- d_size  in  3  AHB hsize encoding.
- d_addr  in  32  data address.
- d_wdata  in  32  write data.
- d_ack, d_err, d_rdata  out  1/1/32  as for the fetch port.
- haddr, hwrite, hsize, htrans  out  32/1/3/2  AHB address-phase signals.
- hwdata  out  32  AHB write data.
- hready, hresp  in  1/1  muxed slave response.
- hr_data  in  32  muxed slave read data.
- muxsel  out  1  response-mux select: 1 = ROM, 0 = RAM.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: if any request is pending, register the grant, the winner's address/control and d_wdata, then go to ADDR. Otherwise stay.
- Arbitration: data wins over fetch unless streak == DATA_STREAK with if_req high. In that case fetch wins.
- Streak counter (3 bits minimum):
  - Increments on each data grant while if_req is high.
  - Clears on a fetch grant, or whenever if_req is low in IDLE.
  - Saturates at DATA_STREAK.
- ADDR: drive htrans=NONSEQ (2'b10) plus haddr/hwrite/hsize from the grant registers. Fetch grants use hwrite=0 and hsize=3'b010.
  - When hready=1: latch muxsel = (haddr < ROM_LIMIT) and go to DATA.
  - When hready=0: hold all signals.
- DATA: htrans=IDLE (2'b00). hwdata is driven from the latched write data; it is 0 for reads.
  - Wait for hready=1.
  - In that cycle, pulse the owner's ack. Drive owner rdata = hr_data and owner err = hresp.
  - Return to IDLE.
- Transfers are not pipelined: one outstanding transfer, minimum 3 cycles each.
- Two-cycle AHB error response (hresp=1/hready=0, then hresp=1/hready=1): completes on the second cycle with err=1. No retry.
- muxsel holds its value outside DATA until the next ADDR acceptance.
- The non-owner's ack/err are 0, and its rdata is 0.
- Writes to the ROM region are issued unchanged; slave error status is returned to the requester.

## Timing
- Reset values (on the rst edge, including mid-transfer):
  - FSM=IDLE, htrans=2'b00, haddr=0, hwrite=0, hsize=0, hwdata=0, muxsel=0, streak=0.
  - All acks/errs/rdata = 0.
  - An abandoned transfer is never acked; requesters reissue.
- Request high in cycle N (IDLE) -> NONSEQ in cycle N+1 -> ack in cycle N+2 at the earliest (hready=1 throughout). Each hready=0 cycle adds one cycle.
- Request sampled in the ack cycle is ignored (FSM is in DATA). It is re-arbitrated in the next IDLE cycle.
- Simultaneous if_req and d_req in IDLE: arbitration rule above. The loser's request is held and served in a later IDLE.
- Address/control outputs are registered. Ack/err/rdata are combinational from hready/hresp/hr_data in DATA.

## Test plan
- Single fetch, if_addr=0x100, hready=1 -> NONSEQ at cycle 1 with haddr=0x100; muxsel=1; if_ack at cycle 2 with if_rdata=hr_data=0xDEADBEEF.
- Data write, d_addr=0x2000_0010, d_wdata=0x1234_5678, d_size=3'b010 -> hwrite=1, muxsel=0, hwdata=0x1234_5678 in DATA; d_ack at cycle 2.
- if_req and d_req both held high continuously, DATA_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- hready low for 3 cycles in DATA on a RAM read -> d_ack delayed to cycle 5; htrans=IDLE throughout the wait.
- Two-cycle error response on a fetch -> if_ack=1 and if_err=1 on the second cycle; FSM returns to IDLE.
- rst asserted during DATA with hready=0 -> next cycle htrans=0, no ack, muxsel=0; a reissued request completes normally.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// AHB-Lite front end sharing one bus between instruction fetch and data load/store.
// One outstanding transfer at a time: IDLE (arbitrate) -> ADDR (NONSEQ) -> DATA (response).
module ahb_bus_arbiter #(
    parameter logic [31:0] ROM_LIMIT   = 32'h0000_8000,
    parameter int          DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic        if_err,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [1:0]  htrans,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic        hresp,
    input  logic [31:0] hr_data,
    output logic        muxsel
);

    localparam int STREAK_W = (DATA_STREAK < 8) ? 3 : $clog2(DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DATA_STREAK);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    state_t state_r;
    state_t state_s;

    logic                any_req_s;
    logic                grant_d_s;
    logic                done_s;
    logic                owner_d_r;
    logic [31:0]         haddr_r;
    logic                hwrite_r;
    logic [2:0]          hsize_r;
    logic [1:0]          htrans_r;
    logic [31:0]         wdata_r;
    logic [31:0]         hwdata_r;
    logic                muxsel_r;
    logic [STREAK_W-1:0] streak_r;

    // Arbitration: data wins unless it has used up its streak while fetch waits.
    always_comb begin
        any_req_s = if_req | d_req;
        if (if_req && (!d_req || (streak_r == STREAK_MAX))) begin
            grant_d_s = 1'b0;
        end else begin
            grant_d_s = d_req;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) state_s = ST_ADDR;
                else           state_s = ST_IDLE;
            end
            ST_ADDR: begin
                if (hready) state_s = ST_DATA;
                else        state_s = ST_ADDR;
            end
            ST_DATA: begin
                if (hready) state_s = ST_IDLE;
                else        state_s = ST_DATA;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Grant, address-phase and data-phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_d_r <= 1'b0;
            haddr_r   <= 32'h0000_0000;
            hwrite_r  <= 1'b0;
            hsize_r   <= 3'b000;
            htrans_r  <= HTRANS_IDLE;
            wdata_r   <= 32'h0000_0000;
            hwdata_r  <= 32'h0000_0000;
            muxsel_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        owner_d_r <= grant_d_s;
                        haddr_r   <= grant_d_s ? d_addr : if_addr;
                        hwrite_r  <= grant_d_s & d_we;
                        hsize_r   <= grant_d_s ? d_size : HSIZE_WORD;
                        htrans_r  <= HTRANS_NONSEQ;
                        wdata_r   <= (grant_d_s && d_we) ? d_wdata : 32'h0000_0000;
                    end
                end
                ST_ADDR: begin
                    if (hready) begin
                        muxsel_r <= (haddr_r < ROM_LIMIT);
                        hwdata_r <= wdata_r;
                        htrans_r <= HTRANS_IDLE;
                    end
                end
                ST_DATA: begin
                    if (hready) hwdata_r <= 32'h0000_0000;
                end
                default: htrans_r <= HTRANS_IDLE;
            endcase
        end
    end

    // Data streak: counts back-to-back data grants taken while fetch is waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_r <= {STREAK_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            if (if_req && grant_d_s) begin
                streak_r <= (streak_r == STREAK_MAX) ? streak_r : streak_r + STREAK_W'(1);
            end else begin
                streak_r <= {STREAK_W{1'b0}};
            end
        end else begin
            streak_r <= streak_r;
        end
    end

    // Completion outputs: steered to the owner only on the accepting DATA cycle.
    always_comb begin
        done_s   = (state_r == ST_DATA) && hready;
        if_ack   = 1'b0;
        if_err   = 1'b0;
        if_rdata = 32'h0000_0000;
        d_ack    = 1'b0;
        d_err    = 1'b0;
        d_rdata  = 32'h0000_0000;
        if (done_s) begin
            if (owner_d_r) begin
                d_ack   = 1'b1;
                d_err   = hresp;
                d_rdata = hr_data;
            end else begin
                if_ack   = 1'b1;
                if_err   = hresp;
                if_rdata = hr_data;
            end
        end else begin
            if_ack = 1'b0;
            d_ack  = 1'b0;
        end
    end

    assign haddr  = haddr_r;
    assign hwrite = hwrite_r;
    assign hsize  = hsize_r;
    assign htrans = htrans_r;
    assign hwdata = hwdata_r;
    assign muxsel = muxsel_r;

endmodule
